seg_word_sequencer: RTL and testbench
=====================================

Name: seg_word_sequencer

Overview:
Sequences a short word onto the single seven-segment display, one character at a time. A small character buffer is loaded through a write port. Each character is then decoded to segment levels and held for a programmable dwell, optionally followed by a blank gap. Playback is one-shot or looping. The block sits between control logic (switch or UART command decoder) and the a..g display pins.

Parameters:
MAX_LEN, 8, character buffer depth (2..16); index width IW = clog2(MAX_LEN)
DWELL_W, 24, width of the dwell counter
GAP_CYCLES, 0, blank cycles inserted after every character (0 = no gap state)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  buffer write strobe
wr_addr  in  IW  buffer write address
wr_char  in  5  character code to write
len  in  IW+1  word length, 1..MAX_LEN, sampled on start
dwell  in  DWELL_W  cycles per character, sampled on start
loop  in  1  1 = repeat word, sampled on start
start  in  1  begin playback (single-cycle pulse)
stop  in  1  abort playback
busy  out  1  high while in SHOW or GAP
done  out  1  one-cycle pulse at end of one-shot playback
char_idx  out  IW  index of character currently displayed
a,b,c,d,e,f,g  out  1 each  segment drives, active-low (0 = lit)

Behaviour:
- One clock domain. Reset is asynchronous assert on rst_n low and synchronous release.
- Reset values: state IDLE, busy=0, done=0, char_idx=0, a..g=1 (blank). All buffer entries are set to code 16 (blank).
- Character codes:
  - 0-15: hex digits 0-F; b and d are lowercase.
  - 16: blank. 17: H. 18: L. 19: P. 20: U. 21: '-'. 22: S (same segments as 5). 23: o. 24: r. 25: n.
  - 26-31: blank.
- Segment outputs are registered from the decoded buffer entry. The outputs are all 1 in IDLE and GAP.
- Writes: when wr_en=1 and busy=0, buf[wr_addr] <= wr_char. Writes while busy are ignored. A wr_addr >= MAX_LEN is ignored.
- FSM states: IDLE, SHOW, GAP.
  - IDLE -> SHOW on start=1 and stop=0 with 1 <= len <= MAX_LEN.
    - On this transition, latch len_q = len, dwell_q = max(dwell,1) and loop_q = loop.
    - Set idx=0 and cnt=dwell_q-1.
    - A start with len=0 or len>MAX_LEN is ignored; stay in IDLE.
  - SHOW: cnt decrements each cycle. When cnt=0:
    - if GAP_CYCLES>0, go to GAP with gcnt=GAP_CYCLES-1;
    - otherwise advance.
  - GAP: gcnt decrements each cycle. When gcnt=0, advance.
  - Advance:
    - if idx < len_q-1: idx+1, reload cnt, go to SHOW;
    - else if loop_q: idx=0, reload cnt, go to SHOW;
    - else go to IDLE with done=1 for exactly one cycle.
- Latency and timing:
  - start sampled at edge t -> busy=1, char_idx=0 and segments show buf[0] after edge t.
  - Each character is displayed for exactly dwell_q cycles.
  - Each gap lasts exactly GAP_CYCLES cycles.
- stop=1 in any state -> IDLE at the next edge: blank, busy=0, char_idx=0, no done pulse.
  - stop has priority over start in the same cycle.
- start while busy is ignored. Changes to len/dwell/loop while busy have no effect.
- Single-character word (len=1, loop=1): stays in SHOW continuously, with cnt reloading. With GAP_CYCLES>0 it alternates between the character and blank.
- dwell counter wraps only by reload and never underflows.

Test Plan:
- Reset: assert rst_n=0 mid-playback -> a..g=1111111, busy=0, done=0, char_idx=0 immediately (asynchronous); buffer reads back blank after release.
- Decode sweep: write codes 0..25 one at a time, start with len=1, dwell=2, loop=0 -> each code yields its segment pattern. Checks: code 5 and code 22 both give {a..g}=0100100; code 8 gives 0000000; code 16 gives 1111111.
- One-shot timing: buffer "HELP" (17,14,18,19), len=4, dwell=3, loop=0, GAP_CYCLES=0 -> each char held exactly 3 cycles, char_idx 0,1,2,3; done pulses once on cycle 12 after start; busy then drops to 0.
- Loop and gap: GAP_CYCLES=2, len=2, dwell=4, loop=1 -> repeating pattern: char0 x4, blank x2, char1 x4, blank x2; done never asserts.
- Stop/start collision: assert stop and start together while busy -> IDLE next edge, blank, no done. Then start with len=0 -> ignored and stays IDLE. Then dwell=0 -> treated as 1-cycle dwell.
- Write lockout: while busy, write code 8 to the current index -> display unchanged. After completion, the same write succeeds.

Source files
------------

// File: rtl/seg_word_sequencer.sv
// rtl/seg_word_sequencer.sv - plays a buffered word on one seven-segment digit
module seg_word_sequencer #(
  parameter  int MAX_LEN    = 8,
  parameter  int DWELL_W    = 24,
  parameter  int GAP_CYCLES = 0,
  localparam int IW         = $clog2(MAX_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [IW-1:0]      wr_addr,
  input  logic [4:0]         wr_char,
  input  logic [IW:0]        len,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               loop,
  input  logic               start,
  input  logic               stop,
  output logic               busy,
  output logic               done,
  output logic [IW-1:0]      char_idx,
  output logic               a,
  output logic               b,
  output logic               c,
  output logic               d,
  output logic               e,
  output logic               f,
  output logic               g
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SHOW = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  // Gap counter only needs to hold GAP_CYCLES-1; keep at least one bit.
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_RELOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
  localparam logic [IW:0]   LEN_MAX    = (IW + 1)'(MAX_LEN);
  localparam logic [6:0]    SEG_BLANK  = 7'b1111111;

  logic [4:0]         buf_q [MAX_LEN];
  logic [1:0]         state, state_n;
  logic [IW-1:0]      idx, idx_n;
  logic [DWELL_W-1:0] cnt, cnt_n;
  logic [GW-1:0]      gcnt, gcnt_n;
  logic [IW:0]        len_q, len_n;
  logic [DWELL_W-1:0] dwell_q, dwell_n;
  logic               loop_q, loop_n;
  logic               done_n;
  logic               adv;
  logic               len_ok;
  logic [6:0]         seg;

  // Active-low pattern, bit 6 = a ... bit 0 = g.
  function automatic logic [6:0] seg_decode(input logic [4:0] code);
    case (code)
      5'd0:    seg_decode = 7'b0000001;
      5'd1:    seg_decode = 7'b1001111;
      5'd2:    seg_decode = 7'b0010010;
      5'd3:    seg_decode = 7'b0000110;
      5'd4:    seg_decode = 7'b1001100;
      5'd5:    seg_decode = 7'b0100100;
      5'd6:    seg_decode = 7'b0100000;
      5'd7:    seg_decode = 7'b0001111;
      5'd8:    seg_decode = 7'b0000000;
      5'd9:    seg_decode = 7'b0000100;
      5'd10:   seg_decode = 7'b0001000;
      5'd11:   seg_decode = 7'b1100000;
      5'd12:   seg_decode = 7'b0110001;
      5'd13:   seg_decode = 7'b1000010;
      5'd14:   seg_decode = 7'b0110000;
      5'd15:   seg_decode = 7'b0111000;
      5'd17:   seg_decode = 7'b1001000;
      5'd18:   seg_decode = 7'b1110001;
      5'd19:   seg_decode = 7'b0011000;
      5'd20:   seg_decode = 7'b1000001;
      5'd21:   seg_decode = 7'b1111110;
      5'd22:   seg_decode = 7'b0100100;
      5'd23:   seg_decode = 7'b1100010;
      5'd24:   seg_decode = 7'b1111010;
      5'd25:   seg_decode = 7'b1101010;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

  assign len_ok = (len != '0) && (len <= LEN_MAX);

  // Next-state: stop wins, then start/dwell/gap sequencing and word advance.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    gcnt_n  = gcnt;
    len_n   = len_q;
    dwell_n = dwell_q;
    loop_n  = loop_q;
    done_n  = 1'b0;
    adv     = 1'b0;
    if (stop) begin
      state_n = IDLE;
      idx_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && len_ok) begin
            state_n = SHOW;
            len_n   = len;
            dwell_n = (dwell == '0) ? DWELL_W'(1) : dwell;
            loop_n  = loop;
            idx_n   = '0;
            cnt_n   = dwell_n - DWELL_W'(1);
          end
        end
        SHOW: begin
          if (cnt == '0) begin
            if (GAP_CYCLES > 0) begin
              state_n = GAP;
              gcnt_n  = GAP_RELOAD;
            end else begin
              adv = 1'b1;
            end
          end else begin
            cnt_n = cnt - DWELL_W'(1);
          end
        end
        GAP: begin
          if (gcnt == '0) adv = 1'b1;
          else            gcnt_n = gcnt - GW'(1);
        end
        default: state_n = IDLE;
      endcase
      if (adv) begin
        if (({1'b0, idx} + (IW + 1)'(1)) < len_q) begin
          idx_n   = idx + IW'(1);
          cnt_n   = dwell_q - DWELL_W'(1);
          state_n = SHOW;
        end else if (loop_q) begin
          idx_n   = '0;
          cnt_n   = dwell_q - DWELL_W'(1);
          state_n = SHOW;
        end else begin
          idx_n   = '0;
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
    end
  end

  // Sequencer registers; segments follow the character that will be shown next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      cnt     <= '0;
      gcnt    <= '0;
      len_q   <= '0;
      dwell_q <= '0;
      loop_q  <= 1'b0;
      done    <= 1'b0;
      seg     <= SEG_BLANK;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      cnt     <= cnt_n;
      gcnt    <= gcnt_n;
      len_q   <= len_n;
      dwell_q <= dwell_n;
      loop_q  <= loop_n;
      done    <= done_n;
      seg     <= (state_n == SHOW) ? seg_decode(buf_q[idx_n]) : SEG_BLANK;
    end
  end

  // Character buffer: writable only while idle, cleared to blank on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LEN; i++) buf_q[i] <= 5'd16;
    end else if (wr_en && (state == IDLE) && ({1'b0, wr_addr} < LEN_MAX)) begin
      buf_q[wr_addr] <= wr_char;
    end
  end

  assign busy     = (state != IDLE);
  assign char_idx = idx;
  assign {a, b, c, d, e, f, g} = seg;

endmodule

// File: tb/tb_seg_word_sequencer.sv
// tb/tb_seg_word_sequencer.sv - directed self-checking bench for seg_word_sequencer
module tb_seg_word_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [4:0]  wr_char = '0;
  logic [3:0]  len = '0;
  logic [23:0] dwell = '0;
  logic        loop = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;

  logic       busy0, done0, busy2, done2;
  logic [2:0] idx0, idx2;
  logic a0, b0, c0, d0, e0, f0, g0;
  logic a2, b2, c2, d2, e2, f2, g2;
  logic [6:0] seg0, seg2;

  int n_cmp = 0;
  int n_fail = 0;

  assign seg0 = {a0, b0, c0, d0, e0, f0, g0};
  assign seg2 = {a2, b2, c2, d2, e2, f2, g2};

  always #5 clk = ~clk;

  seg_word_sequencer #(.MAX_LEN(8), .DWELL_W(24), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
    .len(len), .dwell(dwell), .loop(loop), .start(start), .stop(stop),
    .busy(busy0), .done(done0), .char_idx(idx0),
    .a(a0), .b(b0), .c(c0), .d(d0), .e(e0), .f(f0), .g(g0)
  );

  seg_word_sequencer #(.MAX_LEN(8), .DWELL_W(24), .GAP_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
    .len(len), .dwell(dwell), .loop(loop), .start(start), .stop(stop),
    .busy(busy2), .done(done2), .char_idx(idx2),
    .a(a2), .b(b2), .c(c2), .d(d2), .e(e2), .f(f2), .g(g2)
  );

  typedef struct {
    logic [4:0] code;
    logic [6:0] seg;
  } dec_vec_t;

  dec_vec_t vecs [28];

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] S_H = 7'b1001000;
  localparam logic [6:0] S_E = 7'b0110000;
  localparam logic [6:0] S_L = 7'b1110001;
  localparam logic [6:0] S_P = 7'b0011000;

  logic [6:0] help_seg [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_char(input logic [2:0] addr, input logic [4:0] code);
    wr_en = 1'b1; wr_addr = addr; wr_char = code;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic do_start(input logic [3:0] l, input logic [23:0] dw, input logic lp);
    len = l; dwell = dw; loop = lp; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && (busy0 || busy2); i++) tick();
    check("idle_wait", {30'd0, busy0, busy2}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{5'd0,  7'b0000001}; vecs[1]  = '{5'd1,  7'b1001111};
    vecs[2]  = '{5'd2,  7'b0010010}; vecs[3]  = '{5'd3,  7'b0000110};
    vecs[4]  = '{5'd4,  7'b1001100}; vecs[5]  = '{5'd5,  7'b0100100};
    vecs[6]  = '{5'd6,  7'b0100000}; vecs[7]  = '{5'd7,  7'b0001111};
    vecs[8]  = '{5'd8,  7'b0000000}; vecs[9]  = '{5'd9,  7'b0000100};
    vecs[10] = '{5'd10, 7'b0001000}; vecs[11] = '{5'd11, 7'b1100000};
    vecs[12] = '{5'd12, 7'b0110001}; vecs[13] = '{5'd13, 7'b1000010};
    vecs[14] = '{5'd14, 7'b0110000}; vecs[15] = '{5'd15, 7'b0111000};
    vecs[16] = '{5'd16, 7'b1111111}; vecs[17] = '{5'd17, 7'b1001000};
    vecs[18] = '{5'd18, 7'b1110001}; vecs[19] = '{5'd19, 7'b0011000};
    vecs[20] = '{5'd20, 7'b1000001}; vecs[21] = '{5'd21, 7'b1111110};
    vecs[22] = '{5'd22, 7'b0100100}; vecs[23] = '{5'd23, 7'b1100010};
    vecs[24] = '{5'd24, 7'b1111010}; vecs[25] = '{5'd25, 7'b1101010};
    vecs[26] = '{5'd26, 7'b1111111}; vecs[27] = '{5'd31, 7'b1111111};
    help_seg[0] = S_H; help_seg[1] = S_E; help_seg[2] = S_L; help_seg[3] = S_P;

    // Reset state
    tick(); tick();
    check("rst_seg", {25'd0, seg0}, {25'd0, BLANK});
    check("rst_busy", {31'd0, busy0}, 32'd0);
    check("rst_done", {31'd0, done0}, 32'd0);
    check("rst_idx", {29'd0, idx0}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Decode sweep
    foreach (vecs[i]) begin
      write_char(3'd0, vecs[i].code);
      do_start(4'd1, 24'd2, 1'b0);
      check($sformatf("dec_code%0d", vecs[i].code), {25'd0, seg0}, {25'd0, vecs[i].seg});
      check("dec_busy", {31'd0, busy0}, 32'd1);
      wait_idle();
    end

    // One-shot HELP, dwell 3
    write_char(3'd0, 5'd17); write_char(3'd1, 5'd14);
    write_char(3'd2, 5'd18); write_char(3'd3, 5'd19);
    do_start(4'd4, 24'd3, 1'b0);
    for (int k = 0; k < 12; k++) begin
      check($sformatf("help_idx_c%0d", k), {29'd0, idx0}, k / 3);
      check($sformatf("help_seg_c%0d", k), {25'd0, seg0}, {25'd0, help_seg[k / 3]});
      check($sformatf("help_busy_c%0d", k), {30'd0, busy0, done0}, 32'd2);
      tick();
    end
    check("help_done", {30'd0, busy0, done0}, 32'd1);
    check("help_end_seg", {25'd0, seg0}, {25'd0, BLANK});
    check("help_end_idx", {29'd0, idx0}, 32'd0);
    tick();
    check("help_done_once", {31'd0, done0}, 32'd0);
    wait_idle();

    // Loop with and without gap: H x4 [blank x2] E x4 [blank x2]
    do_start(4'd2, 24'd4, 1'b1);
    for (int k = 0; k < 24; k++) begin
      int p2;
      int p0;
      p2 = k % 12;
      p0 = k % 8;
      check($sformatf("gap_seg_c%0d", k), {25'd0, seg2},
            {25'd0, (p2 < 4) ? S_H : (p2 >= 6 && p2 < 10) ? S_E : BLANK});
      check($sformatf("gap_idx_c%0d", k), {29'd0, idx2}, (p2 < 6) ? 0 : 1);
      check($sformatf("gap_busy_c%0d", k), {30'd0, busy2, done2}, 32'd2);
      check($sformatf("loop_seg_c%0d", k), {25'd0, seg0}, {25'd0, (p0 < 4) ? S_H : S_E});
      check($sformatf("loop_busy_c%0d", k), {30'd0, busy0, done0}, 32'd2);
      tick();
    end

    // Stop and start together while busy
    stop = 1'b1; start = 1'b1; len = 4'd2; dwell = 24'd4;
    tick();
    stop = 1'b0; start = 1'b0;
    check("stop_busy", {30'd0, busy0, busy2}, 32'd0);
    check("stop_seg", {18'd0, seg0, seg2}, {18'd0, BLANK, BLANK});
    check("stop_done", {30'd0, done0, done2}, 32'd0);
    check("stop_idx", {26'd0, idx0, idx2}, 32'd0);
    tick();
    check("stop_no_done", {30'd0, done0, done2}, 32'd0);

    // Illegal lengths are ignored
    do_start(4'd0, 24'd3, 1'b0);
    check("len0_ignored", {30'd0, busy0, busy2}, 32'd0);
    check("len0_seg", {25'd0, seg0}, {25'd0, BLANK});
    do_start(4'd9, 24'd3, 1'b0);
    check("len9_ignored", {30'd0, busy0, busy2}, 32'd0);

    // dwell=0 acts as a 1-cycle dwell
    do_start(4'd1, 24'd0, 1'b0);
    check("dw0_seg", {25'd0, seg0}, {25'd0, S_H});
    check("dw0_busy", {31'd0, busy0}, 32'd1);
    tick();
    check("dw0_done", {30'd0, busy0, done0}, 32'd1);
    wait_idle();

    // Write lockout while busy, then accepted once idle
    do_start(4'd4, 24'd3, 1'b0);
    write_char(3'd0, 5'd8);
    check("lock_seg", {25'd0, seg0}, {25'd0, S_H});
    check("lock_idx", {29'd0, idx0}, 32'd0);
    wait_idle();
    do_start(4'd1, 24'd2, 1'b0);
    check("lock_was_blocked", {25'd0, seg0}, {25'd0, S_H});
    wait_idle();
    write_char(3'd0, 5'd8);
    do_start(4'd1, 24'd2, 1'b0);
    check("write_after_idle", {25'd0, seg0}, {25'd0, 7'b0000000});
    wait_idle();

    // Asynchronous reset mid-playback, buffer cleared
    do_start(4'd4, 24'd5, 1'b1);
    tick();
    check("pre_rst_busy", {31'd0, busy0}, 32'd1);
    #3 rst_n = 1'b0;
    #1;
    check("arst_seg", {18'd0, seg0, seg2}, {18'd0, BLANK, BLANK});
    check("arst_busy", {30'd0, busy0, busy2}, 32'd0);
    check("arst_done", {30'd0, done0, done2}, 32'd0);
    check("arst_idx", {26'd0, idx0, idx2}, 32'd0);
    #2 rst_n = 1'b1;
    tick();
    do_start(4'd1, 24'd1, 1'b0);
    check("buf_clr_busy", {31'd0, busy0}, 32'd1);
    check("buf_clr_seg", {25'd0, seg0}, {25'd0, BLANK});
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
